// File: rtl/noc_types.sv
// -----------------------------------------------------------------------------
// noc_types
//   Shared NoC type definitions for the EXU ALU operand senders.
//   - noc_send_state_t : state encoding of the send-sequencer FSM
//   - NOC_TX_CNT_W     : width of the completed-transfer counter
// -----------------------------------------------------------------------------
package noc_types;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_SEND  = 2'd1,
    SC_FLUSH = 2'd2
  } noc_send_state_t;

  localparam int NOC_TX_CNT_W = 16;

endpackage : noc_types

// File: rtl/el2_exu_noc_send_ctrl.sv
// -----------------------------------------------------------------------------
// el2_exu_noc_send_ctrl
//   Sequences the two EXU ALU NoC serial senders (operand packets 0 and 1) for
//   each issued ALU op. Gates the sender enables, collects one ack per sender,
//   then holds the shared shift-register flush for FLUSH_CYCLES to re-arm both
//   senders. One further request can wait in a single-entry skid slot while a
//   transfer is in flight. A pipeline flush aborts the transfer in progress.
//   Single clock domain (clk_noc), synchronous active-high reset.
//
// Build option:
//   EXU_NOC_SEND_TIMEOUT_EN - adds a SEND-state watchdog (TIMEOUT_CYCLES) that
//                             aborts a transfer whose acks never complete and
//                             sets the sticky timeout_err flag. Undefined: SEND
//                             waits for acks indefinitely, timeout_err is 0.
//
// Ports:
//   clk          in   NoC clock, rising edge
//   rst          in   synchronous active-high reset
//   req_valid    in   ALU op issued, operands stable at the sender inputs
//   req_ready    out  request accepted when req_valid & req_ready
//   pipe_flush   in   pipeline flush (aborts SEND, empties skid slot)
//   ack0/ack1    in   one-cycle pulse: sender 0/1 finished its packet
//   send_en0/1   out  enable to sender 0/1 (high throughout SEND)
//   sr_flush     out  flush to both senders (high throughout FLUSH)
//   busy         out  FSM not idle or skid slot occupied
//   done         out  pulse: transfer completed with both acks
//   aborted      out  pulse: transfer killed by pipe_flush or timeout
//   timeout_err  out  sticky watchdog error, cleared only by rst
//   tx_count     out  completed-transfer counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module el2_exu_noc_send_ctrl
  import noc_types::*;
#(
  parameter int FLUSH_CYCLES = 2
`ifdef EXU_NOC_SEND_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    pipe_flush,
  input  logic                    ack0,
  input  logic                    ack1,
  output logic                    send_en0,
  output logic                    send_en1,
  output logic                    sr_flush,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    timeout_err,
  output logic [NOC_TX_CNT_W-1:0] tx_count
);

  localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);

  noc_send_state_t           r_state;
  noc_send_state_t           w_state_next;
  logic                      r_skid_valid;
  logic [1:0]                r_ack_seen;
  logic [FC_W-1:0]           r_fl_cnt;
  logic                      r_xfer_aborted;
  logic [NOC_TX_CNT_W-1:0]   r_tx_count;

  logic w_accept;
  logic w_acks_all;
  logic w_fl_first;
  logic w_fl_last;
  logic w_abort;
  logic w_timeout;
  logic w_done;
  logic w_flush_entry;

  // A flush in the same cycle blocks acceptance, so a flushed request is never
  // captured into the skid slot nor started.
  assign req_ready  = !r_skid_valid && !pipe_flush;
  assign w_accept   = req_valid && req_ready;

  // Acks arriving this cycle count together with those already recorded, so
  // simultaneous and staggered completion take the same path.
  assign w_acks_all = &(r_ack_seen | {ack1, ack0});

  // The flush down-counter is loaded with FC_LAST on entry and runs to zero.
  assign w_fl_first = (r_state == SC_FLUSH) && (r_fl_cnt == FC_LAST);
  assign w_fl_last  = (r_state == SC_FLUSH) && (r_fl_cnt == '0);

`ifdef EXU_NOC_SEND_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  // Counts SEND cycles; holds zero outside SEND so it starts clean on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != SC_SEND) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == SC_SEND) && (r_to_cnt == TO_LAST) && !w_acks_all;

  // A coincident pipe_flush is the reported cause, so it does not set the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout && !pipe_flush) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every signal driven here gets a default before the case statement so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_abort      = 1'b0;
    unique case (r_state)
      SC_IDLE: begin
        if (w_accept) begin
          w_state_next = SC_SEND;
        end
      end
      SC_SEND: begin
        // pipe_flush beats a completing ack in the same cycle.
        if (pipe_flush || w_timeout) begin
          w_state_next = SC_FLUSH;
          w_abort      = 1'b1;
        end else if (w_acks_all) begin
          w_state_next = SC_FLUSH;
        end
      end
      SC_FLUSH: begin
        // A request taken in the last flush cycle starts directly instead of
        // parking in the skid slot behind an idle FSM.
        if (w_fl_last) begin
          w_state_next = ((r_skid_valid && !pipe_flush) || w_accept) ? SC_SEND : SC_IDLE;
        end
      end
      default: begin
        w_state_next = SC_IDLE;
      end
    endcase
  end

  assign w_flush_entry = (w_state_next == SC_FLUSH) && (r_state != SC_FLUSH);
  assign w_done        = w_fl_last && !r_xfer_aborted;

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= SC_IDLE;
      r_skid_valid   <= 1'b0;
      r_ack_seen     <= 2'b00;
      r_fl_cnt       <= '0;
      r_xfer_aborted <= 1'b0;
      r_tx_count     <= '0;
    end else begin
      r_state <= w_state_next;

      // The skid slot empties on a pipeline flush or when the flush sequence
      // ends (its request either moves into SEND or there was none).
      if (pipe_flush || w_fl_last) begin
        r_skid_valid <= 1'b0;
      end else if (w_accept && (r_state != SC_IDLE)) begin
        r_skid_valid <= 1'b1;
      end

      if (w_flush_entry) begin
        r_fl_cnt <= FC_LAST;
      end else if (r_fl_cnt != '0) begin
        r_fl_cnt <= r_fl_cnt - 1'b1;
      end

      // Acks are recorded only while staying in SEND; leaving SEND clears them,
      // and acks seen in IDLE or FLUSH are dropped.
      if ((r_state == SC_SEND) && (w_state_next == SC_SEND)) begin
        r_ack_seen <= r_ack_seen | {ack1, ack0};
      end else begin
        r_ack_seen <= 2'b00;
      end

      if (w_flush_entry) begin
        r_xfer_aborted <= w_abort;
      end

      if (w_done) begin
        r_tx_count <= r_tx_count + 1'b1;
      end
    end
  end

  assign send_en0 = (r_state == SC_SEND);
  assign send_en1 = (r_state == SC_SEND);
  assign sr_flush = (r_state == SC_FLUSH);
  assign busy     = (r_state != SC_IDLE) || r_skid_valid;
  assign done     = w_done;
  assign aborted  = w_fl_first && r_xfer_aborted;
  assign tx_count = r_tx_count;

endmodule : el2_exu_noc_send_ctrl

// File: tb/tb_el2_exu_noc_send_ctrl.sv
// -----------------------------------------------------------------------------
// tb_el2_exu_noc_send_ctrl
//   Directed self-checking bench for el2_exu_noc_send_ctrl (FLUSH_CYCLES=2).
//   Inputs are driven just after each rising edge; outputs are checked after
//   the inputs settle, well before the next edge. Output vector layout:
//   {send_en0, send_en1, sr_flush, busy, done, aborted, timeout_err}.
// -----------------------------------------------------------------------------
module tb_el2_exu_noc_send_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        pipe_flush = 1'b0;
  logic        ack0 = 1'b0;
  logic        ack1 = 1'b0;
  logic        req_ready;
  logic        send_en0;
  logic        send_en1;
  logic        sr_flush;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        timeout_err;
  logic [15:0] tx_count;

  int          checks   = 0;
  int          failures = 0;
  logic        exp_terr = 1'b0;
  logic [15:0] exp_tx   = 16'd0;

  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_SEND = 7'b1101000;
  localparam logic [6:0] O_FL   = 7'b0011000;
  localparam logic [6:0] O_DONE = 7'b0011100;
  localparam logic [6:0] O_ABT  = 7'b0011010;

  el2_exu_noc_send_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .pipe_flush  (pipe_flush),
    .ack0        (ack0),
    .ack1        (ack1),
    .send_en0    (send_en0),
    .send_en1    (send_en1),
    .sr_flush    (sr_flush),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .timeout_err (timeout_err),
    .tx_count    (tx_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic pf, input logic a0, input logic a1);
    req_valid  = rv;
    pipe_flush = pf;
    ack0       = a0;
    ack1       = a1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_o(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    logic [6:0] e;
    obs = {send_en0, send_en1, sr_flush, busy, done, aborted, timeout_err};
    e   = exp | {6'b000000, exp_terr};
    check(tag, 32'(obs), 32'(e));
  endtask

  // Quick transfer: req, both acks in the first SEND cycle, full flush.
  task automatic xfer_quick(input string tag);
    cyc(); drive(1, 0, 0, 0); check({tag, "_ready"}, 32'(req_ready), 32'd1);
    cyc(); drive(0, 0, 1, 1); check_o({tag, "_send"}, O_SEND);
    cyc(); drive(0, 0, 0, 0); check_o({tag, "_fl"}, O_FL);
    cyc();                    check_o({tag, "_done"}, O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc();                    check_o({tag, "_idle"}, O_IDLE);
    check({tag, "_tx"}, 32'(tx_count), 32'(exp_tx));
  endtask

  initial begin
    // Reset
    cyc(); cyc(); drive(0, 0, 0, 0);
    check_o("reset_outs", O_IDLE);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_tx", 32'(tx_count), 32'd0);
    rst = 1'b0;

    // T1: req c0, ack0 c5, ack1 c7 -> send c1..c7, flush c8..c9, done c9
    cyc(); drive(1, 0, 0, 0); check("t1_c0_ready", 32'(req_ready), 32'd1);
    cyc(); drive(0, 0, 0, 0); check_o("t1_c1", O_SEND);
    cyc(); cyc(); cyc();      check_o("t1_c4", O_SEND);
    cyc(); drive(0, 0, 1, 0); check_o("t1_c5", O_SEND);
    cyc(); drive(0, 0, 0, 0); check_o("t1_c6", O_SEND);
    cyc(); drive(0, 0, 0, 1); check_o("t1_c7", O_SEND);
    cyc(); drive(0, 0, 0, 0); check_o("t1_c8", O_FL);
    cyc();                    check_o("t1_c9", O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc();                    check_o("t1_c10", O_IDLE);
    check("t1_tx", 32'(tx_count), 32'(exp_tx));

    // T2: both acks c4, second req c3 -> flush c5..c6, done c6, SEND c7
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 0, 0, 0); check_o("t2_c1", O_SEND);
    cyc();
    cyc(); drive(1, 0, 0, 0); check("t2_c3_ready", 32'(req_ready), 32'd1);
    cyc(); drive(0, 0, 1, 1); check_o("t2_c4", O_SEND);
    check("t2_c4_skid_full", 32'(req_ready), 32'd0);
    cyc(); drive(0, 0, 0, 0); check_o("t2_c5", O_FL);
    cyc();                    check_o("t2_c6", O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc(); drive(0, 0, 1, 1); check_o("t2_c7_resend", O_SEND);
    check("t2_c7_ready", 32'(req_ready), 32'd1);
    cyc(); drive(0, 0, 0, 0); check_o("t2_c8", O_FL);
    cyc();                    check_o("t2_c9", O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc();                    check_o("t2_c10", O_IDLE);
    check("t2_tx", 32'(tx_count), 32'(exp_tx));

    // T3: pipe_flush c3 during SEND with skid full -> aborted c4, no done
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 0, 0, 0); check_o("t3_c1", O_SEND);
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 1, 0, 0); check("t3_c3_ready", 32'(req_ready), 32'd0);
    cyc(); drive(0, 0, 0, 0); check_o("t3_c4", O_ABT);
    check("t3_c4_skid_empty", 32'(req_ready), 32'd1);
    cyc(); drive(0, 0, 1, 1); check_o("t3_c5", O_FL);
    cyc(); drive(0, 0, 0, 0); check_o("t3_c6", O_IDLE);
    check("t3_tx", 32'(tx_count), 32'(exp_tx));

    // T4: pipe_flush coincident with final ack; then req with pipe_flush in IDLE
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 0, 1, 0); check_o("t4_c1", O_SEND);
    cyc(); drive(0, 0, 0, 0);
    cyc(); drive(0, 1, 0, 1); check_o("t4_c3", O_SEND);
    cyc(); drive(0, 0, 0, 0); check_o("t4_c4", O_ABT);
    cyc();                    check_o("t4_c5", O_FL);
    cyc(); drive(1, 1, 0, 0); check_o("t4_c6", O_IDLE);
    check("t4_idle_flush_ready", 32'(req_ready), 32'd0);
    cyc(); drive(0, 0, 0, 0); check_o("t4_c7_stay_idle", O_IDLE);
    check("t4_tx", 32'(tx_count), 32'(exp_tx));

    // T5: acks in IDLE are ignored; a single ack in SEND does not complete
    cyc(); drive(0, 0, 1, 1); check_o("t5_c0", O_IDLE);
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 0, 0, 1); check_o("t5_c2", O_SEND);
    cyc(); drive(0, 0, 1, 0); check_o("t5_c3_no_early", O_SEND);
    cyc(); drive(0, 0, 0, 0); check_o("t5_c4", O_FL);
    cyc();                    check_o("t5_c5", O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc();                    check_o("t5_c6", O_IDLE);

    // T6: pipe_flush during FLUSH with skid full -> done still fires, skid emptied
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(1, 0, 0, 0); check_o("t6_c1", O_SEND);
    cyc(); drive(0, 0, 1, 1); check_o("t6_c2", O_SEND);
    cyc(); drive(0, 1, 0, 0); check_o("t6_c3", O_FL);
    cyc(); drive(0, 0, 0, 0); check_o("t6_c4", O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc();                    check_o("t6_c5", O_IDLE);
    check("t6_tx", 32'(tx_count), 32'(exp_tx));

    // T7: no acks
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 0, 0, 0); check_o("t7_c1", O_SEND);
`ifdef EXU_NOC_SEND_TIMEOUT_EN
    for (int i = 0; i < 63; i++) cyc();
    check_o("t7_c64_still_send", O_SEND);
    cyc(); exp_terr = 1'b1;   check_o("t7_c65_abort", O_ABT);
    cyc();                    check_o("t7_c66", O_FL);
    cyc();                    check_o("t7_c67_sticky", O_IDLE);
    check("t7_tx", 32'(tx_count), 32'(exp_tx));
`else
    for (int i = 0; i < 79; i++) cyc();
    check_o("t7_c80_still_send", O_SEND);
    drive(0, 0, 1, 1);
    cyc(); drive(0, 0, 0, 0); check_o("t7_c81", O_FL);
    cyc();                    check_o("t7_c82", O_DONE);
    exp_tx = exp_tx + 16'd1;
    cyc();                    check_o("t7_c83", O_IDLE);
    check("t7_tx", 32'(tx_count), 32'(exp_tx));
`endif

    // T8: counter preset near the top, two transfers wrap it to 0
    cyc();
    force dut.r_tx_count = 16'hFFFE;
    #1;
    release dut.r_tx_count;
    exp_tx = 16'hFFFE;
    xfer_quick("t8a");
    xfer_quick("t8b");
    check("t8_wrapped", 32'(tx_count), 32'd0);

    // T9: rst asserted in FLUSH -> reset values next cycle
    cyc(); drive(1, 0, 0, 0);
    cyc(); drive(0, 0, 1, 1); check_o("t9_send", O_SEND);
    cyc(); drive(0, 0, 0, 0); check_o("t9_fl", O_FL);
    rst = 1'b1;
    cyc(); rst = 1'b0; exp_terr = 1'b0; #1;
    check_o("t9_reset_outs", O_IDLE);
    check("t9_reset_ready", 32'(req_ready), 32'd1);
    check("t9_reset_tx", 32'(tx_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_el2_exu_noc_send_ctrl
